trigger_scan_scheduler: RTL and testbench
=========================================

// Module: trigger_scan_scheduler
// PURPOSE
// Time-multiplexes the shared combinational trigger comparator across NUM_ENTRIES programmed trigger entries.
// - Each entry holds its own match mode, tdata2 vector and slot mask.
// - Captures one observation snapshot, scans every entry on the comparator (one entry per cycle) and resolves chains.
// - Returns a per-entry fire bitmap over a valid/ready handshake.
// - Sits between the debug CSR write path, the observation source and the comparator.
// PARAMETERS
// NUM_TRIGGERS  4  rows of the comparator (observation channels per snapshot)
// NUM_SLOTS     4  columns of the comparator (64-bit values per channel)
// NUM_ENTRIES   8  programmable trigger entries; >=2
// PORTS
// clk            in   1                        clock
// rst            in   1                        synchronous reset, active-high
// cfg_we         in   1                        config write strobe; accepted when cfg_we & cfg_ready
// cfg_ready      out  1                        high only in IDLE
// cfg_sel        in   1                        0 = ctrl word, 1 = tdata2 word
// cfg_idx        in   $clog2(NUM_ENTRIES)      entry index
// cfg_slot       in   $clog2(NUM_SLOTS)        tdata2 slot index (ignored for ctrl)
// cfg_wdata      in   64                       ctrl: [3:0] mode, [4] enable, [5] chain, [8+:NUM_SLOTS] slot_mask
// snap_valid     in   1                        observation snapshot offered
// snap_ready     out  1                        high only in IDLE and !rst
// snap_values    in   64 x NUM_TRIGGERS x NUM_SLOTS  observation values
// cmp_csr_values out  64 x NUM_TRIGGERS x NUM_SLOTS  registered snapshot, to comparator
// cmp_tdata2     out  64 x NUM_SLOTS           tdata2 of the entry under scan
// cmp_match_mode out  4                        mode of the entry under scan
// cmp_match      in   1 x NUM_TRIGGERS x NUM_SLOTS   comparator Match result, same cycle
// res_valid      out  1                        result available
// res_ready      in   1                        result consumed
// res_fire       out  NUM_ENTRIES              chain-resolved fire bits
// res_any        out  1                        |res_fire
// res_first      out  $clog2(NUM_ENTRIES)      lowest set index in res_fire; 0 if none
// BEHAVIOUR
// - Reset (sync, rst=1 at edge):
//   - state=IDLE, scan index=0.
//   - All entry ctrl and tdata2 fields = 0 (entries disabled).
//   - Snapshot register = 0.
//   - raw-hit register = 0.
//   - res_valid=0; res_fire, res_any and res_first read 0.
//   - rst mid-scan or mid-report aborts it; the result is dropped.
// - FSM states: IDLE, SCAN, REPORT.
// - IDLE:
//   - snap_ready=1 and cfg_ready=1.
//   - On snap_valid, register snap_values, clear raw hits, idx=0, go to SCAN.
//   - A cfg write and a snapshot in the same cycle are both accepted. The write commits at that edge, and the scan uses the updated config.
// - SCAN:
//   - Lasts exactly NUM_ENTRIES cycles; cfg_ready=0 and snap_ready=0.
//   - Drive cmp_tdata2 and cmp_match_mode from entry idx; cmp_csr_values is driven from the snapshot register.
//   - raw_hit[idx] <= enable[idx] & |(cmp_match[t][s] & slot_mask[idx][s]) over all t,s.
//   - A disabled entry still consumes its cycle, giving fixed latency.
//   - After idx==NUM_ENTRIES-1, go to REPORT.
// - REPORT:
//   - res_valid=1; outputs are held stable until res_ready.
//   - On res_valid & res_ready, go to IDLE; a new snapshot can be accepted the following cycle.
// - Latency: snapshot accepted at edge T -> res_valid high in the cycle after edge T+NUM_ENTRIES.
// - Chain rule:
//   - A group is a maximal run of entries where each entry except the last has chain=1. The group ends at an entry with chain=0 or at entry NUM_ENTRIES-1; the chain bit of the last entry is ignored.
//   - Group fires iff every raw_hit in the group is 1.
//   - Fire is reported only on the group's last entry; other bits of the group are 0.
//   - Any disabled member means the group cannot fire.
// - Unsupported modes (6,7,10,11,14,15) are passed through to the comparator, which returns 0 -> no hit.
// - Width rules:
//   - mode is 4 bits from wdata[3:0].
//   - slot_mask bits beyond NUM_SLOTS are not stored.
//   - cfg_idx >= NUM_ENTRIES is ignored; no write occurs.
// STRUCTURE
// - Package trig_sched_pkg:
//   - state enum {IDLE,SCAN,REPORT}.
//   - Ctrl field offsets (MODE_LSB=0, EN_BIT=4, CHAIN_BIT=5, MASK_LSB=8).
//   - entry_ctrl_t struct {mode, enable, chain, slot_mask}.
// - Sub-module trig_chain_resolver: combinational, raw_hit + chain -> fire bitmap, any, first index.
// TESTING
// - Reset: after rst, the block is in IDLE, res_valid=0, and snap_ready=1 from the first cycle with rst=0.
// - Single equality hit:
//   - Setup: entry 2 mode 0, enabled, slot_mask=0001, tdata2[0]=0xDEAD_BEEF; snapshot[1][0]=0xDEAD_BEEF; all other entries disabled.
//   - Expect: res_fire=0000_0100, res_first=2, res_valid exactly NUM_ENTRIES+1 cycles after acceptance.
// - Chain (group entries 4-5):
//   - Setup: entry 4 chain=1 mode 2 tdata2[1]=0x100, entry 5 chain=0 mode 3 tdata2[1]=0x200; snapshot[0][1]=0x180.
//     - Expect: fire bit 5 only, bit 4 = 0.
//   - Snapshot 0x80: expect res_fire=0.
// - Backpressure plus config stall:
//   - Hold res_ready=0 for 10 cycles.
//   - Expect: outputs stable, cfg_ready=0 and snap_ready=0 throughout.
//   - Release res_ready: next cycle in IDLE; cfg write during REPORT is not accepted.
// - Reset mid-SCAN at idx=3: expect no res_valid, all entries disabled. A following snapshot gives res_fire=0.
// - Simultaneous cfg write (enable entry 0, mode 8, tdata2=0) and snapshot (all values 1): expect res_fire bit 0=1.

Source files
------------

// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the trigger scan scheduler.
// Contents:
//   state_t       scheduler FSM state (IDLE, SCAN, REPORT)
//   *_LSB / *_BIT bit positions of the fields in a ctrl write word
//   entry_ctrl_t  stored per-entry control fields
package trig_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int unsigned MODE_LSB  = 0;
   localparam int unsigned MODE_W    = 4;
   localparam int unsigned EN_BIT    = 4;
   localparam int unsigned CHAIN_BIT = 5;
   localparam int unsigned MASK_LSB  = 8;
   // Upper bound on comparator columns; the stored mask keeps only NUM_SLOTS of these.
   localparam int unsigned MAX_SLOTS = 16;

   typedef struct packed {
      logic [MAX_SLOTS-1:0] slot_mask;
      logic                 chain;
      logic                 enable;
      logic [MODE_W-1:0]    mode;
   } entry_ctrl_t;

endpackage

// File: rtl/trig_chain_resolver.sv
// Combinational chain resolution of per-entry raw hits.
// Ports:
//   raw_hit  in  NUM_ENTRIES    per-entry hit from the scan
//   chain    in  NUM_ENTRIES-1  chain bits of entries 0..N-2 (the last entry always ends a group)
//   fire_c   out NUM_ENTRIES    fire on each group's last entry when every member hit
//   any_c    out 1              |fire_c
//   first_c  out IDX_W          lowest set index of fire_c, 0 if none
module trig_chain_resolver #(
   parameter int unsigned NUM_ENTRIES = 8,
   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] raw_hit,
   input  logic [NUM_ENTRIES-2:0] chain,
   output logic [NUM_ENTRIES-1:0] fire_c,
   output logic                   any_c,
   output logic [IDX_W-1:0]       first_c
);

   // Walk the entries, ANDing hits across a group; emit on the group's last member.
   always_comb begin
      logic acc;
      fire_c = '0;
      acc    = 1'b1;
      for (int i = 0; i < int'(NUM_ENTRIES) - 1; i++) begin
         acc = acc & raw_hit[i];
         if (!chain[i]) begin
            fire_c[i] = acc;
            acc       = 1'b1;
         end
      end
      fire_c[NUM_ENTRIES-1] = acc & raw_hit[NUM_ENTRIES-1];
   end

   // Priority pick of the lowest firing entry.
   always_comb begin
      first_c = '0;
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (fire_c[i]) first_c = IDX_W'(i);
      end
   end

   assign any_c = |fire_c;

endmodule

// File: rtl/trigger_scan_scheduler.sv
// Time-multiplexes one shared trigger comparator over NUM_ENTRIES programmed
// entries: captures a snapshot, scans one entry per cycle, resolves chains and
// returns a fire bitmap over a valid/ready handshake.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we/cfg_ready/cfg_sel/...    entry programming (ctrl word or tdata2 slot), IDLE only
//   snap_valid/snap_ready/values    observation snapshot input
//   cmp_csr_values/tdata2/mode      operands driven to the external comparator
//   cmp_match                       comparator result for the entry under scan
//   res_valid/res_ready/res_*       resolved fire bitmap, summary and first index
module trigger_scan_scheduler
   import trig_sched_pkg::*;
#(
   parameter int unsigned NUM_TRIGGERS = 4,
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned NUM_ENTRIES  = 8,
   localparam int unsigned IDX_W   = $clog2(NUM_ENTRIES),
   localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int unsigned CELLS   = NUM_TRIGGERS * NUM_SLOTS,
   localparam int unsigned SNAP_W  = 64 * CELLS,
   localparam int unsigned TDATA_W = 64 * NUM_SLOTS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   output logic                   cfg_ready,
   input  logic                   cfg_sel,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic [SLOT_W-1:0]      cfg_slot,
   input  logic [63:0]            cfg_wdata,
   input  logic                   snap_valid,
   output logic                   snap_ready,
   input  logic [SNAP_W-1:0]      snap_values,
   output logic [SNAP_W-1:0]      cmp_csr_values,
   output logic [TDATA_W-1:0]     cmp_tdata2,
   output logic [MODE_W-1:0]      cmp_match_mode,
   input  logic [CELLS-1:0]       cmp_match,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [NUM_ENTRIES-1:0] res_fire,
   output logic                   res_any,
   output logic [IDX_W-1:0]       res_first
);

   localparam bit IDX_FULL  = ((1 << IDX_W) == NUM_ENTRIES);
   localparam bit SLOT_FULL = ((1 << SLOT_W) == NUM_SLOTS);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SNAP_W-1:0]    snap_q;
   logic [NUM_ENTRIES-1:0] raw_q;
   entry_ctrl_t          ctrl_q   [NUM_ENTRIES];
   logic [TDATA_W-1:0]   tdata2_q [NUM_ENTRIES];

   logic snap_take_c;
   logic cfg_take_c;
   logic idx_ok_c;
   logic slot_ok_c;
   logic hit_c;
   logic scan_last_c;

   logic [NUM_ENTRIES-1:0] fire_c;
   logic [NUM_ENTRIES-2:0] chain_c;
   logic                   any_c;
   logic [IDX_W-1:0]       first_c;

   // Ctrl bits that carry no stored field.
   logic unused_wdata;
   assign unused_wdata = ^{cfg_wdata[63:MASK_LSB+NUM_SLOTS], cfg_wdata[MASK_LSB-1:CHAIN_BIT+1]};

   // Out-of-range indices only exist when the entry/slot count is not a power of two.
   assign idx_ok_c  = IDX_FULL  || (int'(cfg_idx)  < int'(NUM_ENTRIES));
   assign slot_ok_c = SLOT_FULL || (int'(cfg_slot) < int'(NUM_SLOTS));

   assign cfg_ready   = (state_q == IDLE);
   assign snap_ready  = (state_q == IDLE) && !rst;
   assign res_valid   = (state_q == REPORT);
   assign cfg_take_c  = cfg_we && cfg_ready && idx_ok_c;
   assign scan_last_c = (idx_q == IDX_W'(NUM_ENTRIES - 1));

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_take_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (snap_valid) begin
               snap_take_c = 1'b1;
               idx_d       = '0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (scan_last_c) begin
               idx_d   = '0;
               state_d = REPORT;
            end else begin
               idx_d = IDX_W'(idx_q + 1'b1);
            end
         end
         REPORT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Masked hit of the entry under scan, across every trigger row.
   always_comb begin
      hit_c = 1'b0;
      for (int t = 0; t < int'(NUM_TRIGGERS); t++) begin
         hit_c = hit_c | (|(cmp_match[t*NUM_SLOTS +: NUM_SLOTS] &
                            ctrl_q[idx_q].slot_mask[NUM_SLOTS-1:0]));
      end
      hit_c = hit_c & ctrl_q[idx_q].enable;
   end

   // Snapshot and raw-hit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q <= '0;
         raw_q  <= '0;
      end else if (snap_take_c) begin
         snap_q <= snap_values;
         raw_q  <= '0;
      end else if (state_q == SCAN) begin
         raw_q[idx_q] <= hit_c;
      end
   end

   // Entry configuration storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < int'(NUM_ENTRIES); e++) begin
            ctrl_q[e]   <= '0;
            tdata2_q[e] <= '0;
         end
      end else if (cfg_take_c) begin
         if (!cfg_sel) begin
            ctrl_q[cfg_idx].mode      <= cfg_wdata[MODE_LSB +: MODE_W];
            ctrl_q[cfg_idx].enable    <= cfg_wdata[EN_BIT];
            ctrl_q[cfg_idx].chain     <= cfg_wdata[CHAIN_BIT];
            ctrl_q[cfg_idx].slot_mask <= MAX_SLOTS'(cfg_wdata[MASK_LSB +: NUM_SLOTS]);
         end else if (slot_ok_c) begin
            tdata2_q[cfg_idx][32'(cfg_slot)*64 +: 64] <= cfg_wdata;
         end
      end
   end

   assign cmp_csr_values = snap_q;
   assign cmp_tdata2     = tdata2_q[idx_q];
   assign cmp_match_mode = ctrl_q[idx_q].mode;

   always_comb begin
      for (int e = 0; e < int'(NUM_ENTRIES) - 1; e++) chain_c[e] = ctrl_q[e].chain;
   end

   trig_chain_resolver #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_resolver (
      .raw_hit (raw_q),
      .chain   (chain_c),
      .fire_c  (fire_c),
      .any_c   (any_c),
      .first_c (first_c)
   );

   // Result only presented while reporting; raw hits are still filling during SCAN.
   assign res_fire  = res_valid ? fire_c  : '0;
   assign res_any   = res_valid ? any_c   : 1'b0;
   assign res_first = res_valid ? first_c : '0;

endmodule

// File: tb/tb_trigger_scan_scheduler.sv
// Directed self-checking bench for trigger_scan_scheduler with a small
// behavioural comparator (modes 0 eq, 2 ge, 3 lt, 8 ne; others never match).
module tb_trigger_scan_scheduler;

   localparam int unsigned NT     = 4;
   localparam int unsigned NS     = 4;
   localparam int unsigned NE     = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned SLOT_W = 2;
   localparam int unsigned SNAP_W = 64 * NT * NS;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic              cfg_ready;
   logic              cfg_sel;
   logic [IDX_W-1:0]  cfg_idx;
   logic [SLOT_W-1:0] cfg_slot;
   logic [63:0]       cfg_wdata;
   logic              snap_valid;
   logic              snap_ready;
   logic [SNAP_W-1:0] snap_values;
   logic [SNAP_W-1:0] cmp_csr_values;
   logic [64*NS-1:0]  cmp_tdata2;
   logic [3:0]        cmp_match_mode;
   logic [NT*NS-1:0]  cmp_match;
   logic              res_valid;
   logic              res_ready;
   logic [NE-1:0]     res_fire;
   logic              res_any;
   logic [IDX_W-1:0]  res_first;

   int n_checks = 0;
   int n_pass   = 0;

   trigger_scan_scheduler #(
      .NUM_TRIGGERS (NT),
      .NUM_SLOTS    (NS),
      .NUM_ENTRIES  (NE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_we         (cfg_we),
      .cfg_ready      (cfg_ready),
      .cfg_sel        (cfg_sel),
      .cfg_idx        (cfg_idx),
      .cfg_slot       (cfg_slot),
      .cfg_wdata      (cfg_wdata),
      .snap_valid     (snap_valid),
      .snap_ready     (snap_ready),
      .snap_values    (snap_values),
      .cmp_csr_values (cmp_csr_values),
      .cmp_tdata2     (cmp_tdata2),
      .cmp_match_mode (cmp_match_mode),
      .cmp_match      (cmp_match),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_fire       (res_fire),
      .res_any        (res_any),
      .res_first      (res_first)
   );

   always #5 clk = ~clk;

   // Comparator stand-in.
   always_comb begin
      logic [63:0] v, d;
      cmp_match = '0;
      for (int t = 0; t < int'(NT); t++) begin
         for (int s = 0; s < int'(NS); s++) begin
            v = cmp_csr_values[(t*NS+s)*64 +: 64];
            d = cmp_tdata2[s*64 +: 64];
            case (cmp_match_mode)
               4'd0:    cmp_match[t*NS+s] = (v == d);
               4'd2:    cmp_match[t*NS+s] = (v >= d);
               4'd3:    cmp_match[t*NS+s] = (v <  d);
               4'd8:    cmp_match[t*NS+s] = (v != d);
               default: cmp_match[t*NS+s] = 1'b0;
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic sel, input int idx, input int slot, input logic [63:0] data);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_idx   = IDX_W'(idx);
      cfg_slot  = SLOT_W'(slot);
      cfg_wdata = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic set_val(input int t, input int s, input logic [63:0] v);
      snap_values[(t*NS+s)*64 +: 64] = v;
   endtask

   // Offer the current snapshot (already in IDLE) and count edges until res_valid.
   task automatic run_snap(output int lat);
      snap_valid = 1'b1;
      tick();
      snap_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_res();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic bad;
      rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_slot = '0;
      cfg_wdata = '0; snap_valid = 1'b0; snap_values = '0; res_ready = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_fire",  64'(res_fire),  64'd0);
      check("rst_res_first", 64'(res_first), 64'd0);
      check("rst_snap_ready_in_rst", 64'(snap_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_snap_ready", 64'(snap_ready), 64'd1);
      check("rst_cfg_ready",  64'(cfg_ready),  64'd1);

      // Single equality hit on entry 2
      cfg_write(1'b0, 2, 0, 64'h110);
      cfg_write(1'b1, 2, 0, 64'hDEAD_BEEF);
      snap_values = '0;
      set_val(1, 0, 64'hDEAD_BEEF);
      run_snap(lat);
      check("eq_latency", 64'(lat), 64'(NE + 1));
      check("eq_fire",  64'(res_fire),  64'h04);
      check("eq_any",   64'(res_any),   64'd1);
      check("eq_first", 64'(res_first), 64'd2);
      release_res();

      // Chain group 4-5
      cfg_write(1'b0, 4, 0, 64'h232);
      cfg_write(1'b1, 4, 1, 64'h100);
      cfg_write(1'b0, 5, 0, 64'h213);
      cfg_write(1'b1, 5, 1, 64'h200);
      snap_values = '0;
      set_val(0, 1, 64'h180);
      run_snap(lat);
      check("chain_valid", 64'(res_valid), 64'd1);
      check("chain_fire",  64'(res_fire),  64'h20);
      check("chain_first", 64'(res_first), 64'd5);
      release_res();
      snap_values = '0;
      set_val(0, 1, 64'h80);
      run_snap(lat);
      check("chain_miss_valid", 64'(res_valid), 64'd1);
      check("chain_miss_fire",  64'(res_fire),  64'h00);
      check("chain_miss_any",   64'(res_any),   64'd0);
      check("chain_miss_first", 64'(res_first), 64'd0);
      release_res();

      // Backpressure with a blocked cfg write attempting to disable entry 2
      snap_values = '0;
      set_val(1, 0, 64'hDEAD_BEEF);
      run_snap(lat);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 3'd2; cfg_wdata = 64'h0;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (!res_valid || res_fire != 8'h04 || res_first != 3'd2 || cfg_ready || snap_ready)
            bad = 1'b1;
         tick();
      end
      check("bp_hold_stable", 64'(bad), 64'd0);
      check("bp_fire", 64'(res_fire), 64'h04);
      cfg_we = 1'b0;
      release_res();
      check("bp_idle_valid", 64'(res_valid), 64'd0);
      check("bp_idle_cfg_ready",  64'(cfg_ready),  64'd1);
      check("bp_idle_snap_ready", 64'(snap_ready), 64'd1);
      run_snap(lat);
      check("bp_write_blocked_fire", 64'(res_fire), 64'h04);
      release_res();

      // Reset mid-scan at idx 3
      snap_valid = 1'b1;
      tick();
      snap_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("midrst_snap_ready", 64'(snap_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (res_valid) bad = 1'b1;
         tick();
      end
      check("midrst_no_valid", 64'(bad), 64'd0);
      run_snap(lat);
      check("midrst_latency", 64'(lat), 64'(NE + 1));
      check("midrst_fire", 64'(res_fire), 64'h00);
      release_res();

      // Simultaneous cfg write and snapshot
      for (int t = 0; t < int'(NT); t++)
         for (int s = 0; s < int'(NS); s++) set_val(t, s, 64'd1);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 3'd0; cfg_wdata = 64'hF18;
      snap_valid = 1'b1;
      tick();
      cfg_we = 1'b0; snap_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 50) begin
         tick();
         lat++;
      end
      check("simul_latency", 64'(lat), 64'(NE + 1));
      check("simul_fire",  64'(res_fire),  64'h01);
      check("simul_any",   64'(res_any),   64'd1);
      check("simul_first", 64'(res_first), 64'd0);
      release_res();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
